mario_jump_controller: RTL and testbench

- Sequences Mario's vertical motion: jump trigger, ascent, apex hang, gravity fall and landing.
- Sits beside the horizontal mover. Consumes the same movement tick and drives mario_y into the sprite renderer.
- Owns a velocity/gravity state machine so horizontal and vertical motion stay independent.

---
 rtl/mario_jump_controller.sv | 152 +++++++++++++++
 tb/tb_mario_jump_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mario_jump_controller.sv
// Vertical motion sequencer for Mario: jump trigger, ascent, apex hang, gravity fall, landing.
// Optional macro VARIABLE_JUMP_EN: releasing jump during ascent caps upward velocity at 2.
module mario_jump_controller #(
  parameter int unsigned GROUND_Y    = 360,
  parameter int unsigned JUMP_VEL    = 6,
  parameter int unsigned GRAVITY_DIV = 2,
  parameter int unsigned APEX_TICKS  = 4,
  parameter int unsigned MAX_FALL    = 4
) (
  input  logic        vga_clock,
  input  logic        reset,
  input  logic        move_tick,
  input  logic        jump,
  output logic [31:0] mario_y,
  output logic        airborne,
  output logic [2:0]  jump_state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAscend  = 3'd1,
    StApex    = 3'd2,
    StDescend = 3'd3,
    StLand    = 3'd4
  } state_e;

  localparam logic [3:0]  JumpVel  = 4'(JUMP_VEL);
  localparam logic [3:0]  MaxFall  = 4'(MAX_FALL);
  localparam logic [7:0]  GravLast = 8'(GRAVITY_DIV - 1);
  localparam logic [7:0]  ApexLast = 8'(APEX_TICKS - 1);
  localparam logic [31:0] GroundY  = 32'(GROUND_Y);

  state_e      state_q, state_d;
  logic [31:0] mario_y_q, mario_y_d;
  logic [3:0]  vel_q, vel_d;
  logic [7:0]  grav_cnt_q, grav_cnt_d;
  logic [7:0]  apex_cnt_q, apex_cnt_d;
  logic        jump_prev_q, jump_prev_d;

  // Effective ascent velocity/counter after any early-release cap.
  logic [3:0]  asc_vel;
  logic [7:0]  asc_cnt;
  logic [3:0]  fall_vel;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mario_y_q   <= GroundY;
      vel_q       <= 4'd0;
      grav_cnt_q  <= 8'd0;
      apex_cnt_q  <= 8'd0;
      jump_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mario_y_q   <= mario_y_d;
      vel_q       <= vel_d;
      grav_cnt_q  <= grav_cnt_d;
      apex_cnt_q  <= apex_cnt_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mario_y_d   = mario_y_q;
    vel_d       = vel_q;
    grav_cnt_d  = grav_cnt_q;
    apex_cnt_d  = apex_cnt_q;
    jump_prev_d = jump_prev_q;
    asc_vel     = vel_q;
    asc_cnt     = grav_cnt_q;
    fall_vel    = (vel_q >= MaxFall) ? MaxFall : vel_q + 4'd1;

    if (move_tick) begin
      jump_prev_d = jump;
      unique case (state_q)
        StIdle: begin
          if (jump && !jump_prev_q) begin
            state_d    = StAscend;
            vel_d      = JumpVel;
            grav_cnt_d = 8'd0;
          end
        end

        StAscend: begin
`ifdef VARIABLE_JUMP_EN
          if (!jump && vel_q > 4'd2) begin
            asc_vel = 4'd2;
            asc_cnt = 8'd0;
          end
`endif
          vel_d      = asc_vel;
          grav_cnt_d = asc_cnt;
          if (mario_y_q <= {28'd0, asc_vel}) begin
            mario_y_d  = 32'd0;
            state_d    = StApex;
            apex_cnt_d = 8'd0;
          end else begin
            mario_y_d = mario_y_q - {28'd0, asc_vel};
            if (asc_cnt == GravLast) begin
              grav_cnt_d = 8'd0;
              vel_d      = asc_vel - 4'd1;
              if (asc_vel == 4'd1) begin
                state_d    = StApex;
                apex_cnt_d = 8'd0;
              end
            end else begin
              grav_cnt_d = asc_cnt + 8'd1;
            end
          end
        end

        StApex: begin
          if (apex_cnt_q == ApexLast) begin
            state_d    = StDescend;
            vel_d      = 4'd1;
            grav_cnt_d = 8'd0;
          end else begin
            apex_cnt_d = apex_cnt_q + 8'd1;
          end
        end

        StDescend: begin
          if (mario_y_q + {28'd0, vel_q} >= GroundY) begin
            mario_y_d = GroundY;
            state_d   = StLand;
          end else begin
            mario_y_d = mario_y_q + {28'd0, vel_q};
            if (grav_cnt_q == GravLast) begin
              grav_cnt_d = 8'd0;
              vel_d      = fall_vel;
            end else begin
              grav_cnt_d = grav_cnt_q + 8'd1;
            end
          end
        end

        StLand: begin
          mario_y_d = GroundY;
          state_d   = StIdle;
        end

        default: state_d = StIdle;
      endcase
    end
  end

  assign mario_y    = mario_y_q;
  assign jump_state = state_q;
  assign airborne   = (state_q == StAscend) || (state_q == StApex) || (state_q == StDescend);

endmodule

// File: tb/tb_mario_jump_controller.sv
// Bench for mario_jump_controller: vector table, hand-written corner sequences and a
// randomized run against a trajectory model built from velocity-per-tick formulas.
module tb_mario_jump_controller;

  localparam int GroundY    = 360;
  localparam int JumpVel    = 6;
  localparam int GravityDiv = 2;
  localparam int ApexTicks  = 4;
  localparam int MaxFall    = 4;

  logic        vga_clock = 1'b0;
  logic        reset     = 1'b1;
  logic        move_tick = 1'b0;
  logic        jump      = 1'b0;
  logic [31:0] mario_y, mario_y_low;
  logic        airborne, airborne_low;
  logic [2:0]  jump_state, jump_state_low;

  always #5 vga_clock = ~vga_clock;

  mario_jump_controller u_dut (
    .vga_clock  (vga_clock),
    .reset      (reset),
    .move_tick  (move_tick),
    .jump       (jump),
    .mario_y    (mario_y),
    .airborne   (airborne),
    .jump_state (jump_state)
  );

  mario_jump_controller #(.GROUND_Y(20)) u_dut_low (
    .vga_clock  (vga_clock),
    .reset      (reset),
    .move_tick  (move_tick),
    .jump       (jump),
    .mario_y    (mario_y_low),
    .airborne   (airborne_low),
    .jump_state (jump_state_low)
  );

  typedef struct {
    bit mt;
    bit j;
    int y;
    int st;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int asc_y[12]  = '{354, 348, 343, 338, 334, 330, 327, 324, 322, 320, 319, 318};
  int desc_y[14] = '{319, 320, 322, 324, 327, 330, 334, 338, 342, 346, 350, 354, 358, 360};
  int low_y[4]   = '{14, 8, 3, 0};
  int low_st[4]  = '{1, 1, 1, 2};

  // Model: phase 0..4, ascent velocity = v0 - k/GravityDiv, fall velocity = min(1 + k/GD, MaxFall).
  int m_phase, m_y, m_v0, m_k, m_ak;
  bit m_prev;

  function automatic void model_reset();
    m_phase = 0;
    m_y     = GroundY;
    m_v0    = 0;
    m_k     = 0;
    m_ak    = 0;
    m_prev  = 1'b0;
  endfunction

  function automatic void model_tick(input bit j);
    int v;
    case (m_phase)
      0: if (j && !m_prev) begin
        m_phase = 1;
        m_v0    = JumpVel;
        m_k     = 0;
      end
      1: begin
        v = m_v0 - m_k / GravityDiv;
`ifdef VARIABLE_JUMP_EN
        if (!j && v > 2) begin
          m_v0 = 2;
          m_k  = 0;
          v    = 2;
        end
`endif
        if (m_y <= v) begin
          m_y     = 0;
          m_phase = 2;
          m_ak    = 0;
        end else begin
          m_y -= v;
          m_k++;
          if (m_v0 - m_k / GravityDiv == 0) begin
            m_phase = 2;
            m_ak    = 0;
          end
        end
      end
      2: begin
        m_ak++;
        if (m_ak == ApexTicks) begin
          m_phase = 3;
          m_k     = 0;
        end
      end
      3: begin
        v = 1 + m_k / GravityDiv;
        if (v > MaxFall) v = MaxFall;
        if (m_y + v >= GroundY) begin
          m_y     = GroundY;
          m_phase = 4;
        end else begin
          m_y += v;
          m_k++;
        end
      end
      default: m_phase = 0;
    endcase
    m_prev = j;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input int y, input int st);
    check({tag, " mario_y"}, int'(mario_y), y);
    check({tag, " jump_state"}, int'(jump_state), st);
    check({tag, " airborne"}, int'(airborne), (st >= 1 && st <= 3) ? 1 : 0);
  endtask

  task automatic tick(input bit mt, input bit j);
    @(negedge vga_clock);
    move_tick = mt;
    jump      = j;
    @(posedge vga_clock);
    if (mt) model_tick(j);
    #1;
  endtask

  task automatic do_reset();
    @(negedge vga_clock);
    move_tick = 1'b0;
    jump      = 1'b0;
    reset     = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();

    // Full jump with the button held: identical trajectory with or without early release.
    tbl.push_back('{1'b1, 1'b1, 360, 1});
    for (int i = 0; i < 12; i++) begin
      tbl.push_back('{1'b1, 1'b1, asc_y[i], (i == 11) ? 2 : 1});
      if (i == 4) tbl.push_back('{1'b0, 1'b0, asc_y[i], 1});
    end
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 1'b1, 318, (i == 3) ? 3 : 2});
    for (int i = 0; i < 14; i++) tbl.push_back('{1'b1, 1'b1, desc_y[i], (i == 13) ? 4 : 3});
    tbl.push_back('{1'b1, 1'b1, 360, 0});
    tbl.push_back('{1'b1, 1'b1, 360, 0});

    do_reset();
    check_state("reset", 360, 0);
    foreach (tbl[i]) begin
      tick(tbl[i].mt, tbl[i].j);
      check_state($sformatf("vec%0d", i), tbl[i].y, tbl[i].st);
    end

    // Asynchronous reset mid-ascent takes effect without a clock edge.
    do_reset();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    check_state("pre-reset", 330, 1);
    @(negedge vga_clock);
    #2 reset = 1'b1;
    #1 check_state("async reset", 360, 0);
    reset = 1'b0;
    model_reset();

    // Button held through the whole flight and after landing never rejumps.
    do_reset();
    for (int i = 0; i < 42; i++) tick(1'b1, 1'b1);
    check_state("held", 360, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check_state("repress", 360, 1);

    // move_tick low freezes everything, including jump_prev.
    do_reset();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    check_state("pre-gate", 343, 1);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'($urandom_range(0, 1)));
    check_state("gated", 343, 1);
    tick(1'b1, 1'b1);
    check_state("ungated", 338, 1);

    // Ceiling clamp on a low ground instance.
    do_reset();
    tick(1'b1, 1'b1);
    check("low start", int'(mario_y_low), 20);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1);
      check($sformatf("low y%0d", i), int'(mario_y_low), low_y[i]);
      check($sformatf("low st%0d", i), int'(jump_state_low), low_st[i]);
    end

`ifdef VARIABLE_JUMP_EN
    // Early release gives a short hop.
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check_state("hop0", 354, 1);
    tick(1'b1, 1'b0);
    check_state("hop1", 352, 1);
    tick(1'b1, 1'b0);
    check_state("hop2", 350, 1);
    tick(1'b1, 1'b0);
    check_state("hop3", 349, 1);
    tick(1'b1, 1'b0);
    check_state("hop4", 348, 2);
`endif

    // Randomized run against the model.
    do_reset();
    begin
      bit j_lvl = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
          j_lvl = 1'b0;
        end else begin
          if ($urandom_range(0, 7) == 0) j_lvl = ~j_lvl;
          tick(1'($urandom_range(0, 2) != 0), j_lvl);
        end
        check_state($sformatf("rand%0d", c), m_y, m_phase);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
